isl51002_cfg_sched: RTL and testbench

- Sits between the CPU register bank and the ISL51002 frontend timing regenerator, in the PCLK_i domain.
- Holds shadow copies of hv_in_config/2/3 and commits them atomically at a frame boundary, so the frontend never sees a half-updated mode.
- Monitors the frontend's per-frame measurements (vtotal, interlace, pcnt_frame) and runs a lock state machine that reports input mode stability and mode-change interrupts to firmware.

---
 rtl/isl51002_pkg.sv | 22 ++
 rtl/isl51002_mode_cmp.sv | 23 ++
 rtl/isl51002_cfg_sched.sv | 155 +++++++++++++++
 tb/tb_isl51002_cfg_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isl51002_pkg.sv
// Shared types for the ISL51002 config scheduler: lock states, shadow
// register addresses and the per-frame measurement sample.
package isl51002_pkg;

    typedef enum logic [1:0] {
        LOCK_UNLOCKED = 2'd0,
        LOCK_CHECKING = 2'd1,
        LOCK_LOCKED   = 2'd2,
        LOCK_INVALID  = 2'd3
    } lock_state_e;

    localparam logic [1:0] CFG_ADDR_HV1 = 2'd0;
    localparam logic [1:0] CFG_ADDR_HV2 = 2'd1;
    localparam logic [1:0] CFG_ADDR_HV3 = 2'd2;

    typedef struct packed {
        logic [10:0] vtotal;
        logic        interlace;
        logic [19:0] pcnt_frame;
    } mode_sample_t;

endpackage

// File: rtl/isl51002_mode_cmp.sv
// Frame-to-frame mode compare: exact vtotal/interlace, pcnt within +/-PCNT_TOL.
module isl51002_mode_cmp
    import isl51002_pkg::*;
#(
    parameter logic [19:0] PCNT_TOL = 20'd64
) (
    input  mode_sample_t cur,
    input  mode_sample_t prev,
    output logic         match
);

    logic [20:0] diff;
    logic [20:0] mag;

    always_comb begin
        diff  = {1'b0, cur.pcnt_frame} - {1'b0, prev.pcnt_frame};
        mag   = diff[20] ? (21'd0 - diff) : diff;
        match = (cur.vtotal == prev.vtotal) &&
                (cur.interlace == prev.interlace) &&
                (mag <= {1'b0, PCNT_TOL});
    end

endmodule

// File: rtl/isl51002_cfg_sched.sv
// Shadowed frontend config with frame-aligned atomic commit, plus an input
// mode lock tracker driven by per-frame measurements.
module isl51002_cfg_sched
    import isl51002_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES  = 4,
    parameter logic [19:0] PCNT_TOL       = 20'd64,
    parameter logic [23:0] COMMIT_TIMEOUT = 24'd2000000
) (
    input  logic        PCLK_i,
    input  logic        reset_i,
    input  logic        cfg_wr_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    input  logic        cfg_commit_i,
    input  logic        frame_change_i,
    input  logic [10:0] vtotal_i,
    input  logic        interlace_flag_i,
    input  logic [19:0] pcnt_frame_i,
    input  logic        irq_clr_i,
    output logic [31:0] hv_in_config_o,
    output logic [31:0] hv_in_config2_o,
    output logic [31:0] hv_in_config3_o,
    output logic        cfg_pending_o,
    output logic        mode_locked_o,
    output logic        mode_irq_o,
    output logic [1:0]  lock_state_o
);

    localparam logic [3:0]  LOCK_CNT = 4'(STABLE_FRAMES - 1);
    localparam logic [23:0] TO_LAST  = COMMIT_TIMEOUT - 24'd1;

    logic [31:0]  shadow1, shadow2, shadow3;
    logic         fc_q;
    logic         frame_tick;
    logic         apply;
    logic [23:0]  to_cnt;
    lock_state_e  state;
    logic [3:0]   stable_cnt;
    logic [3:0]   cnt_inc;
    mode_sample_t cur, prev;
    logic         match;

    assign frame_tick = frame_change_i & ~fc_q;
    assign apply      = cfg_pending_o & (frame_tick | (to_cnt == TO_LAST));
    assign cur        = '{vtotal: vtotal_i, interlace: interlace_flag_i, pcnt_frame: pcnt_frame_i};
    assign cnt_inc    = (stable_cnt == 4'hF) ? stable_cnt : stable_cnt + 4'd1;

    isl51002_mode_cmp #(.PCNT_TOL(PCNT_TOL)) u_cmp (
        .cur   (cur),
        .prev  (prev),
        .match (match)
    );

    always_ff @(posedge PCLK_i or posedge reset_i) begin
        if (reset_i) begin
            fc_q            <= 1'b0;
            shadow1         <= '0;
            shadow2         <= '0;
            shadow3         <= '0;
            hv_in_config_o  <= '0;
            hv_in_config2_o <= '0;
            hv_in_config3_o <= '0;
            cfg_pending_o   <= 1'b0;
            to_cnt          <= '0;
        end else begin
            fc_q <= frame_change_i;
            if (cfg_wr_i) begin
                case (cfg_addr_i)
                    CFG_ADDR_HV1: shadow1 <= cfg_wdata_i;
                    CFG_ADDR_HV2: shadow2 <= cfg_wdata_i;
                    CFG_ADDR_HV3: shadow3 <= cfg_wdata_i;
                    default: ;
                endcase
            end
            // Actives take the shadow as it stood before any same-cycle write.
            if (apply) begin
                hv_in_config_o  <= shadow1;
                hv_in_config2_o <= shadow2;
                hv_in_config3_o <= shadow3;
            end
            // A commit arriving while one is still waiting is folded into it.
            if (cfg_commit_i && (!cfg_pending_o || apply)) begin
                cfg_pending_o <= 1'b1;
                to_cnt        <= '0;
            end else if (apply) begin
                cfg_pending_o <= 1'b0;
                to_cnt        <= '0;
            end else if (cfg_pending_o) begin
                to_cnt <= to_cnt + 24'd1;
            end
        end
    end

    always_ff @(posedge PCLK_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= LOCK_UNLOCKED;
            stable_cnt <= '0;
            prev       <= '0;
            mode_irq_o <= 1'b0;
        end else begin
            // A same-cycle set further down overrides this clear.
            if (irq_clr_i)
                mode_irq_o <= 1'b0;
            if (state == LOCK_INVALID) begin
                state      <= LOCK_UNLOCKED;
                stable_cnt <= '0;
            end else if (frame_tick) begin
                prev <= cur;
                case (state)
                    LOCK_UNLOCKED: begin
                        if (match) begin
                            stable_cnt <= 4'd1;
                            if (LOCK_CNT == 4'd0) begin
                                state      <= LOCK_LOCKED;
                                mode_irq_o <= 1'b1;
                            end else begin
                                state <= LOCK_CHECKING;
                            end
                        end else begin
                            stable_cnt <= '0;
                        end
                    end
                    LOCK_CHECKING: begin
                        if (match) begin
                            stable_cnt <= cnt_inc;
                            if (cnt_inc >= LOCK_CNT) begin
                                state      <= LOCK_LOCKED;
                                mode_irq_o <= 1'b1;
                            end
                        end else begin
                            state      <= LOCK_UNLOCKED;
                            stable_cnt <= '0;
                        end
                    end
                    LOCK_LOCKED: begin
                        if (!match) begin
                            state      <= LOCK_UNLOCKED;
                            stable_cnt <= '0;
                            mode_irq_o <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= LOCK_UNLOCKED;
                        stable_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign mode_locked_o = (state == LOCK_LOCKED);
    assign lock_state_o  = state;

endmodule

// File: tb/tb_isl51002_cfg_sched.sv
// Directed bench for isl51002_cfg_sched; expected output snapshots are queued
// with the cycle they must appear in and checked by an independent monitor.
module tb_isl51002_cfg_sched;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        cfg_wr_i = 1'b0;
    logic [1:0]  cfg_addr_i = '0;
    logic [31:0] cfg_wdata_i = '0;
    logic        cfg_commit_i = 1'b0;
    logic        frame_change_i = 1'b0;
    logic [10:0] vtotal_i = '0;
    logic        interlace_flag_i = 1'b0;
    logic [19:0] pcnt_frame_i = '0;
    logic        irq_clr_i = 1'b0;
    logic [31:0] hv_in_config_o, hv_in_config2_o, hv_in_config3_o;
    logic        cfg_pending_o, mode_locked_o, mode_irq_o;
    logic [1:0]  lock_state_o;

    isl51002_cfg_sched #(
        .STABLE_FRAMES  (4),
        .PCNT_TOL       (20'd64),
        .COMMIT_TIMEOUT (24'd16)
    ) dut (
        .PCLK_i           (clk),
        .reset_i          (reset_i),
        .cfg_wr_i         (cfg_wr_i),
        .cfg_addr_i       (cfg_addr_i),
        .cfg_wdata_i      (cfg_wdata_i),
        .cfg_commit_i     (cfg_commit_i),
        .frame_change_i   (frame_change_i),
        .vtotal_i         (vtotal_i),
        .interlace_flag_i (interlace_flag_i),
        .pcnt_frame_i     (pcnt_frame_i),
        .irq_clr_i        (irq_clr_i),
        .hv_in_config_o   (hv_in_config_o),
        .hv_in_config2_o  (hv_in_config2_o),
        .hv_in_config3_o  (hv_in_config3_o),
        .cfg_pending_o    (cfg_pending_o),
        .mode_locked_o    (mode_locked_o),
        .mode_irq_o       (mode_irq_o),
        .lock_state_o     (lock_state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] h1;
        logic [31:0] h2;
        logic [31:0] h3;
        logic        pend;
        logic        locked;
        logic        irq;
        logic [1:0]  st;
    } snap_t;

    int    q_at[$];
    snap_t q_s[$];
    string q_name[$];
    snap_t exp_s;
    int    checks = 0;
    int    errors = 0;

    snap_t act, prv, e;
    string nm;
    initial prv = '0;

    always @(negedge clk) begin
        act = {hv_in_config_o, hv_in_config2_o, hv_in_config3_o,
               cfg_pending_o, mode_locked_o, mode_irq_o, lock_state_o};
        if (q_at.size() > 0 && q_at[0] == cyc) begin
            void'(q_at.pop_front());
            e  = q_s.pop_front();
            nm = q_name.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got h1=%h h2=%h h3=%h pend=%b lock=%b irq=%b st=%0d want h1=%h h2=%h h3=%h pend=%b lock=%b irq=%b st=%0d",
                         nm, cyc, act.h1, act.h2, act.h3, act.pend, act.locked, act.irq, act.st,
                         e.h1, e.h2, e.h3, e.pend, e.locked, e.irq, e.st);
            end
        end else if (act !== prv) begin
            checks++;
            errors++;
            $display("FAIL unexpected_change cyc=%0d got %h was %h", cyc, act, prv);
        end
        if (q_at.size() > 0 && q_at[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL stale_entry %s due=%0d now=%0d", q_name[0], q_at[0], cyc);
            void'(q_at.pop_front());
            void'(q_s.pop_front());
            void'(q_name.pop_front());
        end
        prv = act;
    end

    task automatic nc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_next(input int k, input string name);
        q_at.push_back(cyc + k);
        q_s.push_back(exp_s);
        q_name.push_back(name);
    endtask

    // One frame: rising frame_change held two cycles; exp_s must already hold the post-tick state.
    task automatic frame(input logic [10:0] vt, input logic il, input logic [19:0] pc,
                         input logic clr, input string name);
        vtotal_i         = vt;
        interlace_flag_i = il;
        pcnt_frame_i     = pc;
        frame_change_i   = 1'b1;
        irq_clr_i        = clr;
        expect_next(1, name);
        nc(1);
        irq_clr_i = 1'b0;
        nc(1);
        frame_change_i = 1'b0;
        nc(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset_i = 1'b1;
        nc(2);
        exp_s = '0;
        expect_next(1, "reset_state");
        nc(1);
        reset_i = 1'b0;
        nc(1);

        // Reset while a commit is pending must also wipe the shadow.
        cfg_wr_i = 1'b1; cfg_addr_i = 2'd0; cfg_wdata_i = 32'hA5A5_A5A5; cfg_commit_i = 1'b1;
        exp_s.pend = 1'b1; expect_next(1, "pending_set");
        nc(1);
        cfg_wr_i = 1'b0; cfg_commit_i = 1'b0;
        nc(3);
        exp_s.pend = 1'b0; expect_next(1, "reset_clears_pending");
        #1 reset_i = 1'b1;
        nc(1);
        reset_i = 1'b0;
        nc(1);
        cfg_commit_i = 1'b1;
        exp_s.pend = 1'b1; expect_next(1, "pending_after_reset");
        nc(1);
        cfg_commit_i = 1'b0;
        exp_s.pend = 1'b0;
        frame(11'd101, 1'b0, 20'd0, 1'b0, "reset_shadow_zero");

        // Frame-aligned commit of all three registers; address 3 is dropped.
        cfg_wr_i = 1'b1; cfg_addr_i = 2'd0; cfg_wdata_i = 32'h0320_0280; cfg_commit_i = 1'b1;
        exp_s.pend = 1'b1; expect_next(1, "frame_pending");
        nc(1);
        cfg_commit_i = 1'b0; cfg_addr_i = 2'd1; cfg_wdata_i = 32'h1111_2222;
        nc(1);
        cfg_addr_i = 2'd2; cfg_wdata_i = 32'h3333_4444;
        nc(1);
        cfg_addr_i = 2'd3; cfg_wdata_i = 32'hFFFF_FFFF;
        nc(1);
        cfg_wr_i = 1'b0;
        nc(1);
        exp_s.h1 = 32'h0320_0280; exp_s.h2 = 32'h1111_2222; exp_s.h3 = 32'h3333_4444; exp_s.pend = 1'b0;
        frame(11'd102, 1'b0, 20'd0, 1'b0, "frame_apply");

        // Timeout apply 16 cycles after commit; a second commit is absorbed.
        cfg_wr_i = 1'b1; cfg_addr_i = 2'd0; cfg_wdata_i = 32'hDEAD_BEEF; cfg_commit_i = 1'b1;
        exp_s.pend = 1'b1; expect_next(1, "timeout_pending");
        nc(1);
        cfg_wr_i = 1'b0; cfg_commit_i = 1'b0;
        expect_next(15, "timeout_hold");
        nc(4);
        cfg_commit_i = 1'b1;
        nc(1);
        cfg_commit_i = 1'b0;
        exp_s.h1 = 32'hDEAD_BEEF; exp_s.pend = 1'b0;
        expect_next(11, "timeout_apply");
        nc(14);

        // Write in the apply cycle lands only in the shadow.
        cfg_wr_i = 1'b1; cfg_addr_i = 2'd0; cfg_wdata_i = 32'h1234_5678; cfg_commit_i = 1'b1;
        exp_s.pend = 1'b1; expect_next(1, "wr_apply_pending");
        nc(1);
        cfg_wr_i = 1'b0; cfg_commit_i = 1'b0;
        nc(2);
        cfg_wr_i = 1'b1; cfg_wdata_i = 32'hCAFE_F00D; frame_change_i = 1'b1; vtotal_i = 11'd103;
        exp_s.h1 = 32'h1234_5678; exp_s.pend = 1'b0; expect_next(1, "write_during_apply");
        nc(1);
        cfg_wr_i = 1'b0;
        nc(1);
        frame_change_i = 1'b0;
        nc(2);
        cfg_commit_i = 1'b1;
        exp_s.pend = 1'b1; expect_next(1, "second_commit");
        nc(1);
        cfg_commit_i = 1'b0;
        nc(1);
        // Commit in the apply cycle: apply happens, pending stays, timeout restarts.
        cfg_commit_i = 1'b1; frame_change_i = 1'b1; vtotal_i = 11'd104;
        exp_s.h1 = 32'hCAFE_F00D; expect_next(1, "commit_with_apply");
        nc(1);
        cfg_commit_i = 1'b0;
        expect_next(15, "retimeout_hold");
        nc(1);
        frame_change_i = 1'b0;
        exp_s.pend = 1'b0; expect_next(15, "retimeout_apply");
        nc(17);

        // Lock acquisition with pcnt jitter inside tolerance.
        frame(11'd525, 1'b0, 20'd858000, 1'b0, "lock_t1");
        exp_s.st = 2'd1;
        frame(11'd525, 1'b0, 20'd858040, 1'b0, "lock_t2");
        frame(11'd525, 1'b0, 20'd858000, 1'b0, "lock_t3");
        exp_s.st = 2'd2; exp_s.locked = 1'b1; exp_s.irq = 1'b1;
        frame(11'd525, 1'b0, 20'd858040, 1'b0, "lock_t4");
        frame(11'd525, 1'b0, 20'd858000, 1'b0, "lock_t5_hold");
        irq_clr_i = 1'b1;
        exp_s.irq = 1'b0; expect_next(1, "irq_clear");
        nc(1);
        irq_clr_i = 1'b0;
        nc(1);
        exp_s.st = 2'd0; exp_s.locked = 1'b0; exp_s.irq = 1'b1;
        frame(11'd625, 1'b0, 20'd858000, 1'b1, "lock_loss_set_wins");

        // Tolerance boundary: 64 matches either direction, 65 does not.
        exp_s.st = 2'd1;
        frame(11'd625, 1'b0, 20'd858064, 1'b0, "tol_64_up");
        frame(11'd625, 1'b0, 20'd858000, 1'b0, "tol_64_down");
        exp_s.st = 2'd0;
        frame(11'd625, 1'b0, 20'd858065, 1'b0, "tol_65");
        exp_s.st = 2'd1;
        frame(11'd625, 1'b0, 20'd858065, 1'b0, "recheck_1");
        frame(11'd625, 1'b0, 20'd858065, 1'b0, "recheck_2");
        exp_s.st = 2'd2; exp_s.locked = 1'b1;
        frame(11'd625, 1'b0, 20'd858065, 1'b0, "relock");
        irq_clr_i = 1'b1;
        exp_s.irq = 1'b0; expect_next(1, "irq_clear2");
        nc(1);
        irq_clr_i = 1'b0;
        nc(1);
        exp_s.st = 2'd0; exp_s.locked = 1'b0; exp_s.irq = 1'b1;
        frame(11'd625, 1'b1, 20'd858065, 1'b0, "interlace_loss");

        nc(3);
        while (q_at.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL unchecked_entry %s due=%0d", q_name[0], q_at[0]);
            void'(q_at.pop_front());
            void'(q_s.pop_front());
            void'(q_name.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
